// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
// Drains the TX FIFO onto the serial line: pops one word when the FIFO is
// non-empty, the line is idle and tx_en is set, then sends start bit,
// data_width data bits (LSB first) and the stop period, all timed by the
// shared 16x oversampling tick.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   s_tick              one-clk baud oversample tick
//   tx_en               gate for starting new frames (in-flight frame completes)
//   fifo_empty          TX FIFO empty flag
//   fifo_rd_data        TX FIFO head word, valid while fifo_empty=0
//   fifo_rd             pop strobe, high for the single IDLE cycle that loads b
//   tx                  registered serial line, idle high
//   tx_busy             high from the pop cycle until the stop period ends
//   tx_done_tick        one-clk pulse when the stop period completes
module uart_tx_fifo_reader #(
  parameter int data_width = 8,
  parameter int sb_ticks   = 16,
  parameter int os_ticks   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tick,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int S_MAX = (os_ticks > sb_ticks) ? os_ticks : sb_ticks;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (data_width > 1) ? $clog2(data_width) : 1;

  localparam logic [S_W-1:0] OS_LAST = S_W'(os_ticks - 1);
  localparam logic [S_W-1:0] SB_LAST = S_W'(sb_ticks - 1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(data_width - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]            state;
  logic [S_W-1:0]        s;
  logic [N_W-1:0]        n;
  logic [data_width-1:0] b;
  logic                  tx_q;
  logic                  done_q;

  // The pop is combinational so the FIFO head is captured into b on the same
  // edge the FIFO advances. Gated by reset so nothing is lost in a reset cycle.
  assign fifo_rd      = !reset && (state == IDLE) && tx_en && !fifo_empty;
  assign tx_busy      = (state != IDLE) || fifo_rd;
  assign tx           = tx_q;
  assign tx_done_tick = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Line follows the current state one clock later.
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= b[0];
        default: tx_q <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (fifo_rd) begin
            b     <= fifo_rd_data;
            s     <= '0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == OS_LAST) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == OS_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) state <= STOP;
              else             n     <= n + N_W'(1);
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        default: begin
          if (s_tick) begin
            if (s == SB_LAST) begin
              s      <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
